// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 16-bit multicycle core.
// Accepts a framed byte stream (LEN_HI, LEN_LO, 2*N data bytes, checksum),
// writes big-endian 16-bit words sequentially into instruction memory and
// holds the core in reset until the frame has arrived with a valid checksum.
// Optional idle timeout inside a frame: define PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              restart,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    // One past the last addressable word; frames ending beyond it are rejected.
    localparam logic [32:0]       CAPACITY = 33'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;

    logic                accept;
    logic [15:0]         len_in;
    logic [32:0]         frame_end;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

    assign byte_ready = !rst && (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                                 S_DATA_LO, S_CHK});
    assign accept     = byte_valid && byte_ready;
    assign len_in     = {len_q[15:8], byte_in};
    assign frame_end  = 33'(START_ADDR) + 33'(len_in);

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign core_rst = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERROR);

    // Next-state, datapath and write-strobe decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept) begin
            sum_d = sum_q + byte_in;
        end

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_in;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_in;
                    if (frame_end > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (len_in == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = {hi_q, byte_in};
                    addr_d  = ADDR_W'(START_ADDR + 32'(cnt_q));
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_q + 16'd1 == len_q) ? S_CHK : S_DATA_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (sum_d == 8'h00) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_LEN_HI;
                    cnt_d   = '0;
                    sum_d   = '0;
                    addr_d  = START_A;
                end
            end
            default: state_d = S_LEN_HI;
        endcase

`ifdef PROG_LOADER_TIMEOUT_EN
        // Counter is zero on state entry because it only advances while the
        // state is held without a transfer.
        idle_d = '0;
        if ((state_q inside {S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK}) && !accept) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                state_d = S_ERROR;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= START_A;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    // Idle-cycle counter for the in-frame timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Table-driven frames,
// hand-written multi-cycle sequences and random frames, all checked against
// a frame-level reference model.
module tb_prog_loader;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned START_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              restart;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .START_ADDR  (START_ADDR),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .restart    (restart),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] act_wr[$];
    logic [23:0] exp_wr[$];

    // Every write strobe seen by instruction memory, as {addr, data}.
    always @(negedge clk) begin
        if (im_we) act_wr.push_back({im_addr, im_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one byte starting just after a rising edge; returns just after
    // the edge on which it transferred, with byte_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        int   guard;
        logic rdy;
        guard      = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            guard++;
        end while (!rdy && guard < 100);
        #1 byte_valid = 1'b0;
        chk("byte accepted", 32'(rdy), 32'd1);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        restart    = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clk);
        chk("ready during rst", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
        chk("restart done", 32'(done), 32'd0);
        chk("restart err", 32'(err), 32'd0);
        chk("restart core_rst", 32'(core_rst), 32'd1);
        chk("restart ready", 32'(byte_ready), 32'd1);
        chk("restart addr", 32'(im_addr), START_ADDR);
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: decode length, list the words and their
    // addresses, and judge the byte sum of everything consumed.
    task automatic model_frame(input logic [7:0] fb[$], output bit m_done,
                               output bit m_err, output int used);
        int unsigned len;
        int unsigned s;
        exp_wr.delete();
        len = int'(fb[0]) * 256 + int'(fb[1]);
        if (START_ADDR + len > (1 << ADDR_W)) begin
            m_done = 1'b0;
            m_err  = 1'b1;
            used   = 2;
            return;
        end
        used = 2 * int'(len) + 3;
        for (int i = 0; i < int'(len); i++)
            exp_wr.push_back({ADDR_W'(START_ADDR + i), fb[2 + 2*i], fb[3 + 2*i]});
        s = 0;
        for (int i = 0; i < used; i++) s += fb[i];
        m_done = ((s % 256) == 0);
        m_err  = !m_done;
    endtask

    task automatic run_frame(input logic [7:0] fb[$], input int maxgap, input string tag);
        bit m_done;
        bit m_err;
        int used;
        int g;
        model_frame(fb, m_done, m_err, used);
        act_wr.delete();
        for (int i = 0; i < used; i++) begin
            g = int'($urandom_range(maxgap, 0));
            repeat (g) begin @(posedge clk); #1; end
            send_byte(fb[i]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " err"}, 32'(err), 32'(m_err));
        chk({tag, " core_rst"}, 32'(core_rst), 32'(!m_done));
        chk({tag, " ready after"}, 32'(byte_ready), 32'd0);
        chk({tag, " write count"}, 32'(act_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < act_wr.size()) chk({tag, " write"}, 32'(act_wr[i]), 32'(exp_wr[i]));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [0:7][7:0] b;
        int              nb;
        int              maxgap;
        bit              exp_done;
        bit              exp_err;
        int              exp_nwr;
    } vec_t;

    vec_t        tbl[5];
    logic [7:0]  fq[$];
    int unsigned rs;
    int          rlen;
    logic [7:0]  ck;

    initial begin
        tbl[0] = '{b: 64'h00021234ABCD4000, nb: 7, maxgap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2};
        tbl[1] = '{b: 64'h00021234ABCD4100, nb: 7, maxgap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 2};
        tbl[2] = '{b: 64'h00021234ABCD4000, nb: 7, maxgap: 5, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2};
        tbl[3] = '{b: 64'h0000000000000000, nb: 3, maxgap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 0};
        tbl[4] = '{b: 64'h0101000000000000, nb: 2, maxgap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 0};

        byte_in    = 8'h00;
        byte_valid = 1'b0;
        restart    = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset core_rst", 32'(core_rst), 32'd1);
        chk("reset im_we", 32'(im_we), 32'd0);
        chk("reset im_addr", 32'(im_addr), START_ADDR);
        chk("reset im_wdata", 32'(im_wdata), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset ready", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;

        // Nominal frame with write latency and core_rst release timing.
        act_wr.delete();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        chk("lat we0", 32'(im_we), 32'd1);
        chk("lat addr0", 32'(im_addr), 32'd0);
        chk("lat data0", 32'(im_wdata), 32'h1234);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("we pulse width", 32'(im_we), 32'd0);
        chk("addr held", 32'(im_addr), 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'hAB);
        send_byte(8'hCD);
        @(negedge clk);
        chk("lat we1", 32'(im_we), 32'd1);
        chk("lat addr1", 32'(im_addr), 32'd1);
        chk("lat data1", 32'(im_wdata), 32'hABCD);
        @(posedge clk);
        #1;
        byte_in    = 8'h40;
        byte_valid = 1'b1;
        @(negedge clk);
        chk("core_rst before chk", 32'(core_rst), 32'd1);
        chk("ready in chk", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b1;
        @(negedge clk);
        chk("core_rst released", 32'(core_rst), 32'd0);
        chk("done after chk", 32'(done), 32'd1);
        chk("ready in done", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        @(negedge clk);
        chk("no extra writes", 32'(act_wr.size()), 32'd2);
        @(posedge clk);
        #1;
        do_restart();

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            fq.delete();
            for (int j = 0; j < tbl[i].nb; j++) fq.push_back(tbl[i].b[j]);
            run_frame(fq, tbl[i].maxgap, $sformatf("tbl%0d", i));
            @(negedge clk);
            chk($sformatf("tbl%0d done", i), 32'(done), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d err", i), 32'(err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d nwr", i), 32'(act_wr.size()), 32'(tbl[i].exp_nwr));
            @(posedge clk);
            #1;
            do_restart();
        end

        // restart outside DONE/ERROR must be ignored.
        act_wr.delete();
        send_byte(8'h00);
        send_byte(8'h01);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h44);
        @(negedge clk);
        chk("ign restart done", 32'(done), 32'd1);
        chk("ign restart nwr", 32'(act_wr.size()), 32'd1);
        chk("ign restart write", (act_wr.size() > 0) ? 32'(act_wr[0]) : 32'hFFFF_FFFF, 32'h005566);
        @(posedge clk);
        #1;
        do_restart();

        // rst mid-frame after the third data byte, then the full frame.
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        act_wr.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst im_we", 32'(im_we), 32'd0);
        chk("midrst core_rst", 32'(core_rst), 32'd1);
        chk("midrst addr", 32'(im_addr), START_ADDR);
        @(posedge clk);
        #1;
        chk("midrst stale writes", 32'(act_wr.size()), 32'd0);
        fq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame(fq, 0, "after rst");
        do_restart();

        // Full-capacity frame: last word lands at the top address.
        fq.delete();
        fq.push_back(8'h01);
        fq.push_back(8'h00);
        rs = 1;
        for (int i = 0; i < 512; i++) begin
            ck = 8'($urandom);
            fq.push_back(ck);
            rs += ck;
        end
        fq.push_back(8'(256 - (rs % 256)));
        run_frame(fq, 0, "full");
        chk("full last addr", 32'(im_addr), 32'((1 << ADDR_W) - 1));
        do_restart();

        // Random frames with random gaps and occasional corruption.
        for (int it = 0; it < 25; it++) begin
            fq.delete();
            if ($urandom_range(7, 0) == 0) begin
                fq.push_back(8'h01);
                fq.push_back(8'($urandom_range(255, 1)));
            end else begin
                rlen = int'($urandom_range(6, 0));
                fq.push_back(8'h00);
                fq.push_back(8'(rlen));
                rs = 32'(rlen);
                for (int k = 0; k < 2 * rlen; k++) begin
                    ck = 8'($urandom);
                    fq.push_back(ck);
                    rs += ck;
                end
                ck = 8'(256 - (rs % 256));
                if ($urandom_range(3, 0) == 0) ck = ck + 8'($urandom_range(255, 1));
                fq.push_back(ck);
            end
            run_frame(fq, 5, $sformatf("rand%0d", it));
            do_restart();
        end

`ifdef PROG_LOADER_TIMEOUT_EN
        // 19 idle cycles after a data byte is tolerated.
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (19) begin @(posedge clk); #1; end
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h40);
        @(negedge clk);
        chk("to19 done", 32'(done), 32'd1);
        chk("to19 err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        do_restart();

        // 20 idle cycles trips the timeout.
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (19) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("to20 err early", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("to20 err", 32'(err), 32'd1);
        chk("to20 core_rst", 32'(core_rst), 32'd1);
        chk("to20 ready", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        do_restart();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the 16-bit multicycle processor top.
- Receives a framed byte stream over a valid/ready handshake, assembles 16-bit big-endian words and writes them sequentially into instruction memory.
- Holds the processor core in reset until the whole frame has arrived and its checksum matches, then releases it.
- Frame format: LEN_HI, LEN_LO, then 2*N data bytes (high byte first), then one checksum byte.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- START_ADDR, 0, word address of the first loaded instruction.
- TIMEOUT_CYC, 1000, maximum idle cycles between bytes inside a frame (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- byte_in  input  8  incoming stream byte
- byte_valid  input  1  byte_in is valid this cycle
- byte_ready  output  1  loader accepts a byte this cycle; a byte transfers when valid && ready
- restart  input  1  one-cycle pulse; from DONE/ERROR, start a new frame
- im_we  output  1  instruction-memory write strobe, one-cycle pulse per word
- im_addr  output  ADDR_W  instruction-memory word address
- im_wdata  output  16  instruction-memory write data
- core_rst  output  1  reset to the processor core, active-high
- done  output  1  frame loaded and checksum correct
- err  output  1  frame rejected

Behaviour:
- Reset: state=LEN_HI; core_rst=1; im_we=0; im_addr=START_ADDR; im_wdata=0; done=0; err=0; count=0; sum=0.
- byte_ready is 0 while rst=1. Otherwise it is 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- Every accepted byte is added into sum, an 8-bit running sum modulo 256. This includes the length bytes and the checksum byte.
- State transitions (each on an accepted byte unless noted):
  - LEN_HI -> LEN_LO: latch len[15:8].
  - LEN_LO: latch len[7:0], then:
    - START_ADDR+len > 2^ADDR_W -> ERROR.
    - len==0 -> CHK.
    - otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO: latch high byte.
  - DATA_LO: the cycle after acceptance has im_we=1, im_wdata={hi,lo}, im_addr=START_ADDR+count. count increments in that same cycle. Next state is CHK if count+1==len, else DATA_HI. im_addr holds its value between writes.
  - CHK: if the sum including the checksum byte ==0 -> DONE, else ERROR.
  - DONE: done=1; core_rst=0 starting the cycle after the checksum byte is accepted.
  - ERROR: err=1; core_rst stays 1. Instruction-memory contents are undefined.
- Write latency is exactly 1 cycle from the DATA_LO handshake to im_we. A back-to-back stream gives at most one write every 2 cycles.
- A byte arriving with byte_valid=1 in DONE or ERROR is not accepted (byte_ready=0).
- restart is honoured only in DONE or ERROR. It returns to LEN_HI next cycle; clears done, err, count and sum; sets core_rst=1 and im_addr=START_ADDR. restart in any other state is ignored.
- rst mid-frame aborts immediately to the reset values. A partial load is discarded; no im_we follows.
- With len = 2^ADDR_W - START_ADDR the last write uses im_addr = 2^ADDR_W - 1. im_addr never wraps.
- im_we is never asserted in LEN_*, CHK, DONE or ERROR except for the 1-cycle post-DATA_LO pulse.

Optional Feature:
- Macro: PROG_LOADER_TIMEOUT_EN.
- When defined: an idle counter runs in LEN_LO, DATA_HI, DATA_LO and CHK. It clears on every accepted byte and on state entry. When it reaches TIMEOUT_CYC the loader enters ERROR (err=1, core_rst=1). LEN_HI never times out.
- When undefined: no counter exists, and the loader waits indefinitely in every state.

Test Plan:
- Nominal frame 00 02 12 34 AB CD 40, one byte per cycle -> im_we pulses with (addr 0, 0x1234) and (addr 1, 0xABCD); done=1; core_rst falls 1 cycle after 0x40 is accepted; err=0.
- Same frame with the checksum byte 0x41 -> err=1, done=0, core_rst stays 1; byte_ready=0 afterwards. restart pulse, then the correct frame -> done=1.
- Empty frame 00 00 00 -> no im_we; done=1. Oversize length 01 01 (257 words, ADDR_W=8) -> err=1 right after LEN_LO; no im_we.
- Nominal frame with byte_valid toggling randomly (gaps of 0-5 cycles) -> identical writes and result as the back-to-back case; no byte dropped or duplicated.
- rst asserted for 1 cycle after the 3rd data byte, then the full nominal frame -> exactly two im_we pulses (addr 0, 1) after reset, no stale write; done=1.
- PROG_LOADER_TIMEOUT_EN with TIMEOUT_CYC=20: stall 20 cycles after byte 0x12 -> err=1 at cycle 20; a 19-cycle stall -> no error, and the frame completes with done=1.
